// File: rtl/drop_scheduler_pkg.sv
// Shared definitions for the LED-catch drop scheduler: cell geometry,
// FSM state encoding, LFSR seed and small arithmetic helpers.
package drop_scheduler_pkg;

   localparam int          ADDR_W     = 6;
   localparam logic [2:0]  ROW_GROUND = 3'd7;
   localparam logic [7:0]  LFSR_SEED  = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_STEP  = 3'd2,
      ST_CHECK = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting towards the MSB
   function automatic logic [7:0] lfsr_next(input logic [7:0] q);
      return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
   endfunction

   // Score accumulation that sticks at 255 instead of wrapping
   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

   // Lives decrement that floors at zero
   function automatic logic [1:0] sat_sub_lives(input logic [1:0] lives_in, input logic [7:0] misses);
      logic [1:0] result;
      if (misses >= {6'd0, lives_in}) begin
         result = 2'd0;
      end else begin
         result = lives_in - misses[1:0];
      end
      return result;
   endfunction

endpackage

// File: rtl/drop_scheduler_lfsr8.sv
// Free-running 8-bit pseudo-random source; its low bits pick spawn columns.
module drop_scheduler_lfsr8
   import drop_scheduler_pkg::*;
(
   input  logic       clock,
   input  logic       resetn,
   output logic [7:0] lfsr
);

   logic [7:0] lfsr_r;

   // Advance the sequence every clock regardless of game state
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         lfsr_r <= LFSR_SEED;
      end else begin
         lfsr_r <= lfsr_next(lfsr_r);
      end
   end

   assign lfsr = lfsr_r;

endmodule

// File: rtl/drop_scheduler.sv
// Game sequencer for the 8x8 LED-catch matrix: shared step tick, fixed pool
// of falling-object slots, catch/miss resolution, score, lives and game-over.
module drop_scheduler
   import drop_scheduler_pkg::*;
#(
   parameter int SLOTS     = 4,
   parameter int TICK_DIV  = 25000000,
   parameter int LIVES     = 3,
   parameter int SPAWN_GAP = 3
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic                      start,
   input  logic                      pause,
   input  logic [ADDR_W-1:0]         addr_plyr,
   output logic [SLOTS-1:0]          obj_valid,
   output logic [ADDR_W*SLOTS-1:0]   obj_addr,
   output logic [7:0]                score,
   output logic [1:0]                lives,
   output logic                      game_over,
   output logic                      catch_pulse,
   output logic                      miss_pulse
);

   localparam int                TICK_W    = $clog2(TICK_DIV);
   localparam int                SP_W      = $clog2(SPAWN_GAP + 1);
   localparam int                CNT_W     = $clog2(SLOTS + 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [SP_W-1:0]   SP_GAP    = SP_W'(SPAWN_GAP);

   state_t                    state_r;
   state_t                    state_next_s;
   logic [TICK_W-1:0]         tick_r;
   logic [SP_W-1:0]           spawn_cnt_r;
   logic [SLOTS-1:0]          valid_r;
   logic [ADDR_W*SLOTS-1:0]   addr_r;
   logic [7:0]                score_r;
   logic [1:0]                lives_r;
   logic                      game_over_r;
   logic                      catch_pulse_r;
   logic                      miss_pulse_r;
   logic [7:0]                lfsr_s;

   logic [SLOTS-1:0]          valid_step_s;
   logic [ADDR_W*SLOTS-1:0]   addr_step_s;
   logic [CNT_W-1:0]          catch_cnt_s;
   logic [CNT_W-1:0]          miss_cnt_s;
   logic [SP_W-1:0]           spawn_inc_s;
   logic                      spawn_fire_s;
   logic                      free_found_s;
   logic                      game_init_s;

   logic                      unused_plyr_row_s;
   logic                      unused_lfsr_hi_s;

   assign unused_plyr_row_s = ^addr_plyr[2:0];
   assign unused_lfsr_hi_s  = ^lfsr_s[7:3];

   drop_scheduler_lfsr8 u_lfsr (
      .clock  (clock),
      .resetn (resetn),
      .lfsr   (lfsr_s)
   );

   // A new game is armed from IDLE or OVER when start is seen
   assign game_init_s = ((state_r == ST_IDLE) || (state_r == ST_OVER)) && start;

   // FSM state register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state: RUN waits for the tick wrap, STEP and CHECK last one cycle each
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_next_s = ST_RUN;
            else       state_next_s = ST_IDLE;
         end
         ST_RUN: begin
            if (!pause && (tick_r == TICK_LAST)) state_next_s = ST_STEP;
            else                                 state_next_s = ST_RUN;
         end
         ST_STEP: begin
            state_next_s = ST_CHECK;
         end
         ST_CHECK: begin
            if (lives_r == 2'd0) state_next_s = ST_OVER;
            else                 state_next_s = ST_RUN;
         end
         ST_OVER: begin
            if (start) state_next_s = ST_RUN;
            else       state_next_s = ST_OVER;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Step datapath: advance, resolve or spawn each slot from its pre-step value
   always_comb begin
      valid_step_s = valid_r;
      addr_step_s  = addr_r;
      catch_cnt_s  = {CNT_W{1'b0}};
      miss_cnt_s   = {CNT_W{1'b0}};
      free_found_s = 1'b0;
      spawn_inc_s  = spawn_cnt_r + SP_W'(1);
      spawn_fire_s = (spawn_inc_s == SP_GAP);
      for (int i = 0; i < SLOTS; i++) begin
         if (valid_r[i]) begin
            if (addr_r[ADDR_W*i +: 3] == ROW_GROUND) begin
               valid_step_s[i] = 1'b0;
               if (addr_r[ADDR_W*i+3 +: 3] == addr_plyr[5:3]) begin
                  catch_cnt_s = catch_cnt_s + CNT_W'(1);
               end else begin
                  miss_cnt_s = miss_cnt_s + CNT_W'(1);
               end
            end else begin
               addr_step_s[ADDR_W*i +: 3] = addr_r[ADDR_W*i +: 3] + 3'd1;
            end
         end else if (spawn_fire_s && !free_found_s) begin
            // only slots already free before this step can take the new object
            free_found_s                     = 1'b1;
            valid_step_s[i]                  = 1'b1;
            addr_step_s[ADDR_W*i +: ADDR_W] = {lfsr_s[2:0], 3'd0};
         end else begin
            valid_step_s[i] = 1'b0;
         end
      end
   end

   // Game registers: init on start, tick in RUN, slot/score update in STEP, end check in CHECK
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         tick_r        <= {TICK_W{1'b0}};
         spawn_cnt_r   <= {SP_W{1'b0}};
         valid_r       <= {SLOTS{1'b0}};
         addr_r        <= {(ADDR_W*SLOTS){1'b0}};
         score_r       <= 8'd0;
         lives_r       <= 2'd0;
         game_over_r   <= 1'b0;
         catch_pulse_r <= 1'b0;
         miss_pulse_r  <= 1'b0;
      end else begin
         catch_pulse_r <= 1'b0;
         miss_pulse_r  <= 1'b0;
         case (state_r)
            ST_IDLE, ST_OVER: begin
               if (game_init_s) begin
                  tick_r      <= {TICK_W{1'b0}};
                  spawn_cnt_r <= {SP_W{1'b0}};
                  valid_r     <= {SLOTS{1'b0}};
                  addr_r      <= {(ADDR_W*SLOTS){1'b0}};
                  score_r     <= 8'd0;
                  lives_r     <= 2'(LIVES);
                  game_over_r <= 1'b0;
               end
            end
            ST_RUN: begin
               if (!pause) begin
                  if (tick_r == TICK_LAST) tick_r <= {TICK_W{1'b0}};
                  else                     tick_r <= tick_r + TICK_W'(1);
               end
            end
            ST_STEP: begin
               valid_r       <= valid_step_s;
               addr_r        <= addr_step_s;
               score_r       <= sat_add8(score_r, 8'(catch_cnt_s));
               lives_r       <= sat_sub_lives(lives_r, 8'(miss_cnt_s));
               spawn_cnt_r   <= spawn_fire_s ? {SP_W{1'b0}} : spawn_inc_s;
               catch_pulse_r <= (catch_cnt_s != {CNT_W{1'b0}});
               miss_pulse_r  <= (miss_cnt_s != {CNT_W{1'b0}});
            end
            ST_CHECK: begin
               if (lives_r == 2'd0) begin
                  valid_r     <= {SLOTS{1'b0}};
                  game_over_r <= 1'b1;
               end
            end
            default: begin
               valid_r <= valid_r;
            end
         endcase
      end
   end

   assign obj_valid   = valid_r;
   assign obj_addr    = addr_r;
   assign score       = score_r;
   assign lives       = lives_r;
   assign game_over   = game_over_r;
   assign catch_pulse = catch_pulse_r;
   assign miss_pulse  = miss_pulse_r;

endmodule

// File: tb/tb_drop_scheduler.sv
// Directed bench for drop_scheduler with a short tick (one step every 6 clocks).
module tb_drop_scheduler;

   logic        clock = 1'b0;
   logic        resetn;
   logic        start;
   logic        pause;
   logic [5:0]  addr_plyr;
   logic [3:0]  obj_valid;
   logic [23:0] obj_addr;
   logic [7:0]  score;
   logic [1:0]  lives;
   logic        game_over;
   logic        catch_pulse;
   logic        miss_pulse;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0]  m_lfsr;
   logic [7:0]  m_prev;
   logic [2:0]  col [0:4];
   logic [23:0] addr_snap;

   drop_scheduler #(
      .SLOTS     (4),
      .TICK_DIV  (4),
      .LIVES     (3),
      .SPAWN_GAP (1)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .start       (start),
      .pause       (pause),
      .addr_plyr   (addr_plyr),
      .obj_valid   (obj_valid),
      .obj_addr    (obj_addr),
      .score       (score),
      .lives       (lives),
      .game_over   (game_over),
      .catch_pulse (catch_pulse),
      .miss_pulse  (miss_pulse)
   );

   always #5 clock = ~clock;

   // Reference LFSR; m_prev holds the value seen during the cycle before the latest edge
   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         m_lfsr <= 8'hA5;
         m_prev <= 8'hA5;
      end else begin
         m_prev <= m_lfsr;
         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_step();
      repeat (6) @(posedge clock);
      #1;
   endtask

   initial begin
      resetn    = 1'b0;
      start     = 1'b0;
      pause     = 1'b0;
      addr_plyr = 6'd0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_score", 32'(score), 32'd0);
      check("rst_lives", 32'(lives), 32'd0);
      check("rst_valid", 32'(obj_valid), 32'd0);
      check("rst_over", 32'(game_over), 32'd0);
      check("rst_pulses", 32'({catch_pulse, miss_pulse}), 32'd0);
      resetn = 1'b1;
      @(posedge clock);
      #1;
      check("idle_lives", 32'(lives), 32'd0);

      // start game; start stays high into RUN and must be ignored there
      start = 1'b1;
      @(posedge clock);
      #1;
      check("init_lives", 32'(lives), 32'd3);
      check("init_score", 32'(score), 32'd0);
      repeat (5) @(posedge clock);
      #1;
      col[0] = m_prev[2:0];
      check("s1_valid", 32'(obj_valid), 32'h1);
      check("s1_addr0", 32'(obj_addr[5:0]), 32'({col[0], 3'd0}));
      start = 1'b0;
      next_step();
      col[1] = m_prev[2:0];
      check("s2_addr", 32'(obj_addr[11:0]), 32'({col[1], 3'd0, col[0], 3'd1}));
      next_step();
      col[2] = m_prev[2:0];
      next_step();
      col[3] = m_prev[2:0];
      check("s4_valid", 32'(obj_valid), 32'hF);
      next_step();
      // pool full: fifth spawn dropped, no slot overwritten
      check("s5_valid", 32'(obj_valid), 32'hF);
      check("s5_addr", 32'(obj_addr),
            32'({col[3], 3'd1, col[2], 3'd2, col[1], 3'd3, col[0], 3'd4}));
      check("s5_lives", 32'(lives), 32'd3);

      // pause for 20 cycles: objects must not move
      addr_snap = obj_addr;
      pause = 1'b1;
      repeat (20) @(posedge clock);
      #1;
      check("pause_addr", 32'(obj_addr), 32'(addr_snap));
      check("pause_valid", 32'(obj_valid), 32'hF);
      pause = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      check("s6_addr", 32'(obj_addr),
            32'({col[3], 3'd2, col[2], 3'd3, col[1], 3'd4, col[0], 3'd5}));
      next_step();
      next_step();
      // catch first object at step 9
      addr_plyr = {col[0], 3'd0};
      next_step();
      check("catch_score", 32'(score), 32'd1);
      check("catch_pulse", 32'(catch_pulse), 32'd1);
      check("catch_nomiss", 32'(miss_pulse), 32'd0);
      check("catch_valid", 32'(obj_valid), 32'hE);
      check("catch_lives", 32'(lives), 32'd3);
      @(posedge clock);
      #1;
      check("catch_pulse_end", 32'(catch_pulse), 32'd0);

      // miss second object at step 10
      addr_plyr = {col[1] ^ 3'd7, 3'd0};
      repeat (5) @(posedge clock);
      #1;
      col[4] = m_prev[2:0];
      check("miss_lives", 32'(lives), 32'd2);
      check("miss_pulse", 32'(miss_pulse), 32'd1);
      check("miss_score", 32'(score), 32'd1);
      check("miss_valid", 32'(obj_valid), 32'hD);
      check("respawn_addr", 32'(obj_addr[5:0]), 32'({col[4], 3'd0}));
      @(posedge clock);
      #1;
      check("miss_pulse_end", 32'(miss_pulse), 32'd0);

      addr_plyr = {col[2] ^ 3'd7, 3'd0};
      repeat (5) @(posedge clock);
      #1;
      check("miss2_lives", 32'(lives), 32'd1);
      addr_plyr = {col[3] ^ 3'd7, 3'd0};
      next_step();
      check("miss3_lives", 32'(lives), 32'd0);
      check("miss3_pulse", 32'(miss_pulse), 32'd1);
      @(posedge clock);
      #1;
      check("over_flag", 32'(game_over), 32'd1);
      check("over_valid", 32'(obj_valid), 32'd0);
      check("over_score", 32'(score), 32'd1);

      // restart from OVER
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      check("restart_lives", 32'(lives), 32'd3);
      check("restart_score", 32'(score), 32'd0);
      check("restart_over", 32'(game_over), 32'd0);
      repeat (5) @(posedge clock);
      #1;
      check("restart_valid", 32'(obj_valid), 32'h1);
      check("restart_addr", 32'(obj_addr[5:0]), 32'({m_prev[2:0], 3'd0}));
      next_step();

      // asynchronous reset mid-RUN
      #2;
      resetn = 1'b0;
      #1;
      check("arst_valid", 32'(obj_valid), 32'd0);
      check("arst_addr", 32'(obj_addr), 32'd0);
      check("arst_lives", 32'(lives), 32'd0);
      check("arst_misc", 32'({score, game_over, catch_pulse, miss_pulse}), 32'd0);
      repeat (2) @(posedge clock);
      resetn = 1'b1;
      repeat (2) @(posedge clock);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
